mod_inv: RTL

- Sequential modular inverter over GF(p), p = 2^255-19, for the EdDSA25519 accelerator datapath.
- Computes C = A^-1 mod p using the binary extended Euclidean algorithm, one reduction step per clock.
- Used for the projective-to-affine conversion: the core hands it Z and receives Z^-1.
- Completes the field-arithmetic set next to the adder/subtractor and multiplier. It uses the same p and the same reduced-operand convention (all values in [0, p)).

---
 rtl/mod_inv.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mod_inv.sv
// Sequential modular inverter over GF(2^255-19) using the binary extended Euclidean
// algorithm, one reduction step per clock; used for projective-to-affine Z^-1.
module mod_inv #(
    parameter int unsigned BIT_LENGTH = 256,
    parameter int unsigned ITER_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIT_LENGTH-1:0] A,
    output logic [BIT_LENGTH-1:0] C,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned           CW  = $clog2(ITER_LIMIT + 1);
    localparam logic [BIT_LENGTH-1:0] ONE = BIT_LENGTH'(1);
    localparam logic [BIT_LENGTH-1:0] P   = (ONE << 255) - BIT_LENGTH'(19);
    localparam logic [CW-1:0]         LIM = CW'(ITER_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOOP, S_DONE} state_e;

    state_e                state_q;
    logic [BIT_LENGTH-1:0] a_q;
    logic [BIT_LENGTH-1:0] u_q;
    logic [BIT_LENGTH-1:0] v_q;
    logic [BIT_LENGTH-1:0] x1_q;
    logic [BIT_LENGTH-1:0] x2_q;
    logic [BIT_LENGTH-1:0] c_q;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    // x/2 mod p: an odd x is made even by adding p in a widened sum before the shift
    function automatic logic [BIT_LENGTH-1:0] halve(input logic [BIT_LENGTH-1:0] x);
        logic [BIT_LENGTH:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, P} : '0);
        return BIT_LENGTH'(s >> 1);
    endfunction

    // Operands are below p < 2^BIT_LENGTH, so the wrapped x-y+p is exact
    function automatic logic [BIT_LENGTH-1:0] modsub(input logic [BIT_LENGTH-1:0] x,
                                                     input logic [BIT_LENGTH-1:0] y);
        return (x >= y) ? (x - y) : (x - y + P);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= A;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (a_q == '0 || a_q >= P) begin
                        c_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        u_q     <= a_q;
                        v_q     <= P;
                        x1_q    <= ONE;
                        x2_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (u_q == ONE) begin
                        c_q     <= x1_q;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (v_q == ONE) begin
                        c_q     <= x2_q;
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == LIM) begin
                        c_q     <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (!u_q[0]) begin
                        u_q  <= u_q >> 1;
                        x1_q <= halve(x1_q);
                    end else if (!v_q[0]) begin
                        v_q  <= v_q >> 1;
                        x2_q <= halve(x2_q);
                    end else if (u_q >= v_q) begin
                        u_q  <= u_q - v_q;
                        x1_q <= modsub(x1_q, x2_q);
                    end else begin
                        v_q  <= v_q - u_q;
                        x2_q <= modsub(x2_q, x1_q);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign C    = c_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
